// File: rtl/sdu_acq_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdu_acq_seq : shot sequencer (TX -> listen delay -> ACQ -> gap) with
//               averaging and playback drain for the receive buffer.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module sdu_acq_seq #(
  parameter int SMP_W = 16,
  parameter int AVE_W = 16,
  parameter int TX_W  = 8,
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SMP_W-1:0] cfg_num_samples,
  input  logic [AVE_W-1:0] cfg_num_aves,
  input  logic [TX_W-1:0]  cfg_tx_len,
  input  logic [SMP_W-1:0] cfg_listen_dly,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             sdu_rx_strobe,
  output logic             tx_pulse,
  output logic             sdu_rx_en,
  output logic             sdu_seq_done_strobe,
  output logic             sdu_ave_done_strobe,
  output logic             busy,
  output logic [AVE_W-1:0] ave_idx,
  output logic             acq_done,
  output logic             cfg_err
);

  localparam int C_W1  = (SMP_W > GAP_W) ? SMP_W : GAP_W;
  localparam int CNT_W = (C_W1 > TX_W) ? C_W1 : TX_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TX    = 3'd1,
    S_DLY   = 3'd2,
    S_ACQ   = 3'd3,
    S_GAP   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AVE_W-1:0]   ave_idx_q, ave_idx_d;
  logic               seen_q, seen_d;
  logic [SMP_W-1:0]   smp_q, dly_q;
  logic [AVE_W-1:0]   aves_q;
  logic [TX_W-1:0]    tx_len_q;
  logic [GAP_W-1:0]   gap_q;
  logic               tx_pulse_q, rx_en_q, seq_q, ave_q, busy_q, acq_done_q, cfg_err_q;
  logic               acq_done_d, cfg_err_d, latch_d;
  logic               go_shot, go_dly, go_acq;

  logic               w_idle, w_last, w_final;
  logic [SMP_W-1:0]   w_smp, w_dly;
  logic [AVE_W-1:0]   w_aves;
  logic [TX_W-1:0]    w_tx_len;
  logic [GAP_W-1:0]   w_gap, w_gap_len;

  always_comb begin
    // In IDLE the live cfg inputs are used, so the first shot needs no extra latch cycle
    w_idle    = (state_q == S_IDLE);
    w_smp     = w_idle ? cfg_num_samples : smp_q;
    w_dly     = w_idle ? cfg_listen_dly  : dly_q;
    w_aves    = w_idle ? cfg_num_aves    : aves_q;
    w_tx_len  = w_idle ? cfg_tx_len      : tx_len_q;
    w_gap     = w_idle ? cfg_gap         : gap_q;
    w_gap_len = (w_gap < GAP_W'(2)) ? GAP_W'(2) : w_gap;

    state_d    = state_q;
    cnt_d      = cnt_q;
    ave_idx_d  = ave_idx_q;
    seen_d     = seen_q;
    acq_done_d = 1'b0;
    cfg_err_d  = 1'b0;
    latch_d    = 1'b0;
    go_shot    = 1'b0;
    go_dly     = 1'b0;
    go_acq     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (cfg_num_samples == '0 || cfg_num_aves == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            latch_d   = 1'b1;
            ave_idx_d = '0;
            go_shot   = 1'b1;
          end
        end
      end
      S_TX: begin
        if (cnt_q == CNT_W'(1)) go_dly = 1'b1;
        else                    cnt_d  = cnt_q - CNT_W'(1);
      end
      S_DLY: begin
        if (cnt_q == CNT_W'(1)) go_acq = 1'b1;
        else                    cnt_d  = cnt_q - CNT_W'(1);
      end
      S_ACQ: begin
        if (cnt_q == CNT_W'(1)) begin
          if (ave_idx_q == w_aves - AVE_W'(1)) begin
            state_d = S_DRAIN;
            seen_d  = 1'b0;
          end else begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(w_gap_len);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(1)) begin
          ave_idx_d = ave_idx_q + AVE_W'(1);
          go_shot   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (sdu_rx_strobe) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d    = S_IDLE;
          acq_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Zero-length phases fall straight through to the next one
    if (go_shot) begin
      if (w_tx_len != '0) begin
        state_d = S_TX;
        cnt_d   = CNT_W'(w_tx_len);
      end else begin
        go_dly = 1'b1;
      end
    end
    if (go_dly) begin
      if (w_dly != '0) begin
        state_d = S_DLY;
        cnt_d   = CNT_W'(w_dly);
      end else begin
        go_acq = 1'b1;
      end
    end
    if (go_acq) begin
      state_d = S_ACQ;
      cnt_d   = CNT_W'(w_smp);
    end

    if (abort && !w_idle) begin
      state_d    = S_IDLE;
      seen_d     = 1'b0;
      acq_done_d = 1'b0;
    end

    w_last  = (state_d == S_ACQ) && (cnt_d == CNT_W'(1));
    w_final = (ave_idx_d == w_aves - AVE_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ave_idx_q  <= '0;
      seen_q     <= 1'b0;
      smp_q      <= '0;
      dly_q      <= '0;
      aves_q     <= '0;
      tx_len_q   <= '0;
      gap_q      <= '0;
      tx_pulse_q <= 1'b0;
      rx_en_q    <= 1'b0;
      seq_q      <= 1'b0;
      ave_q      <= 1'b0;
      busy_q     <= 1'b0;
      acq_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ave_idx_q  <= ave_idx_d;
      seen_q     <= seen_d;
      if (latch_d) begin
        smp_q    <= cfg_num_samples;
        dly_q    <= cfg_listen_dly;
        aves_q   <= cfg_num_aves;
        tx_len_q <= cfg_tx_len;
        gap_q    <= cfg_gap;
      end
      tx_pulse_q <= (state_d == S_TX);
      rx_en_q    <= (state_d == S_ACQ);
      seq_q      <= w_last && !w_final;
      ave_q      <= w_last && w_final;
      busy_q     <= (state_d != S_IDLE);
      acq_done_q <= acq_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tx_pulse            = tx_pulse_q;
  assign sdu_rx_en           = rx_en_q;
  assign sdu_seq_done_strobe = seq_q;
  assign sdu_ave_done_strobe = ave_q;
  assign busy                = busy_q;
  assign ave_idx             = ave_idx_q;
  assign acq_done            = acq_done_q;
  assign cfg_err             = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sdu_acq_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sdu_acq_seq : self-checking bench, per-cycle timeline reference model.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_sdu_acq_seq;
  localparam int SMP_W = 16;
  localparam int AVE_W = 16;
  localparam int TX_W  = 8;
  localparam int GAP_W = 16;
  localparam int VW    = AVE_W + 7;

  logic             clk = 1'b0;
  logic             reset, start, abort, sdu_rx_strobe;
  logic [SMP_W-1:0] cfg_num_samples, cfg_listen_dly;
  logic [AVE_W-1:0] cfg_num_aves;
  logic [TX_W-1:0]  cfg_tx_len;
  logic [GAP_W-1:0] cfg_gap;
  logic             tx_pulse, sdu_rx_en, sdu_seq_done_strobe, sdu_ave_done_strobe;
  logic             busy, acq_done, cfg_err;
  logic [AVE_W-1:0] ave_idx;
  logic [VW-1:0]    obs_v;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_v [0:1023];
  bit            drv_rx [0:1023];
  bit            in_drain [0:1023];
  int            exp_len, exp_abort, last_idx;

  always #5 clk = ~clk;

  sdu_acq_seq #(.SMP_W(SMP_W), .AVE_W(AVE_W), .TX_W(TX_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_num_samples(cfg_num_samples), .cfg_num_aves(cfg_num_aves),
    .cfg_tx_len(cfg_tx_len), .cfg_listen_dly(cfg_listen_dly), .cfg_gap(cfg_gap),
    .sdu_rx_strobe(sdu_rx_strobe), .tx_pulse(tx_pulse), .sdu_rx_en(sdu_rx_en),
    .sdu_seq_done_strobe(sdu_seq_done_strobe), .sdu_ave_done_strobe(sdu_ave_done_strobe),
    .busy(busy), .ave_idx(ave_idx), .acq_done(acq_done), .cfg_err(cfg_err)
  );

  assign obs_v = {ave_idx, tx_pulse, sdu_rx_en, sdu_seq_done_strobe,
                  sdu_ave_done_strobe, busy, acq_done, cfg_err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Output vector layout: {ave_idx, tx, rx_en, seq, ave, busy, done, err}
  function automatic logic [VW-1:0] mk(bit tx, bit rx, bit sq, bit av, bit bz,
                                       bit dn, bit er, int idx);
    return {AVE_W'(idx), tx, rx, sq, av, bz, dn, er};
  endfunction

  // Expected output per cycle after a start at offset 0
  task automatic build(input int n, input int a, input int tx, input int dly, input int gap,
                       input int w, input int h, input int ab_shot, input int ab_off);
    int p, g2, ab_at;
    int acq_start [0:7];
    for (int i = 0; i < 1024; i++) begin
      exp_v[i] = '0; drv_rx[i] = 1'b0; in_drain[i] = 1'b0;
    end
    g2 = (gap < 2) ? 2 : gap;
    p  = 1;
    for (int k = 0; k < a; k++) begin
      for (int j = 0; j < tx; j++)  begin exp_v[p] = mk(1,0,0,0,1,0,0,k); p++; end
      for (int j = 0; j < dly; j++) begin exp_v[p] = mk(0,0,0,0,1,0,0,k); p++; end
      acq_start[k] = p;
      for (int j = 0; j < n; j++) begin
        exp_v[p] = mk(0, 1, (j == n-1) && (k < a-1), (j == n-1) && (k == a-1), 1, 0, 0, k);
        p++;
      end
      if (k < a-1)
        for (int j = 0; j < g2; j++) begin exp_v[p] = mk(0,0,0,0,1,0,0,k); p++; end
    end
    for (int j = 0; j < w + h + 1; j++) begin
      in_drain[p] = 1'b1;
      drv_rx[p]   = (j >= w) && (j < w + h);
      exp_v[p]    = mk(0,0,0,0,1,0,0,a-1);
      p++;
    end
    exp_v[p] = mk(0,0,0,0,0,1,0,a-1); p++;
    exp_v[p] = mk(0,0,0,0,0,0,0,a-1); p++;
    exp_v[p] = mk(0,0,0,0,0,0,0,a-1);
    exp_len   = p;
    exp_abort = -1;
    if (ab_shot >= 0) begin
      ab_at = acq_start[ab_shot] + ab_off;
      for (int o = ab_at + 1; o <= ab_at + 3; o++) begin
        exp_v[o] = mk(0,0,0,0,0,0,0,ab_shot); in_drain[o] = 1'b0;
      end
      exp_len   = ab_at + 3;
      exp_abort = ab_at;
    end
  endtask

  task automatic run(input int n, input int a, input int tx, input int dly, input int gap,
                     input int w, input int h, input int ab_shot, input int ab_off,
                     input bit noisy, input string tag);
    build(n, a, tx, dly, gap, w, h, ab_shot, ab_off);
    @(posedge clk); #1;
    cfg_num_samples = SMP_W'(n); cfg_num_aves = AVE_W'(a); cfg_tx_len = TX_W'(tx);
    cfg_listen_dly = SMP_W'(dly); cfg_gap = GAP_W'(gap);
    start = 1'b1; abort = 1'b0; sdu_rx_strobe = 1'b0;
    for (int o = 1; o <= exp_len; o++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (o == exp_abort);
      sdu_rx_strobe = in_drain[o] ? drv_rx[o] : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
      if (noisy) begin
        cfg_num_samples = SMP_W'($urandom); cfg_num_aves = AVE_W'($urandom);
        cfg_tx_len = TX_W'($urandom); cfg_listen_dly = SMP_W'($urandom);
        cfg_gap = GAP_W'($urandom);
        if (exp_v[o][2] && o != exp_abort) start = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      check(tag, 32'(obs_v), 32'(exp_v[o]));
    end
    start = 1'b0; abort = 1'b0; sdu_rx_strobe = 1'b0;
    last_idx = int'(exp_v[exp_len][VW-1:7]);
  endtask

  // Start in IDLE that must not launch a sequence (bad config, or abort alongside)
  task automatic idle_start(input int n, input int a, input bit ab, input string tag);
    @(posedge clk); #1;
    cfg_num_samples = SMP_W'(n); cfg_num_aves = AVE_W'(a); cfg_tx_len = TX_W'(2);
    cfg_listen_dly = SMP_W'(1); cfg_gap = GAP_W'(0);
    start = 1'b1; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check(tag, 32'(obs_v), 32'(mk(0,0,0,0,0,0,!ab,last_idx)));
    @(posedge clk); #1;
    @(negedge clk);
    check(tag, 32'(obs_v), 32'(mk(0,0,0,0,0,0,0,last_idx)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, a, tx, dly, gap, w, h, ab_shot, ab_off;
    reset = 1'b1; start = 1'b0; abort = 1'b0; sdu_rx_strobe = 1'b0;
    cfg_num_samples = '0; cfg_num_aves = '0; cfg_tx_len = '0;
    cfg_listen_dly = '0; cfg_gap = '0; last_idx = 0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(obs_v), 32'(0));
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(obs_v), 32'(0));

    run(8, 1, 3, 4, 0, 0, 8, -1, 0, 1'b0, "single_shot");
    run(8, 4, 2, 1, 0, 1, 3, -1, 0, 1'b0, "averaging");
    run(5, 2, 0, 0, 3, 0, 2, -1, 0, 1'b0, "zero_tx_dly");
    run(6, 4, 1, 2, 0, 0, 2, 1, 3, 1'b0, "abort_acq2");
    run(4, 2, 1, 1, 1, 0, 1, -1, 0, 1'b0, "after_abort");
    run(1, 1, 255, 0, 0, 0, 1, -1, 0, 1'b0, "tx_len_max");
    run(3, 3, 2, 2, 5, 2, 2, -1, 0, 1'b1, "busy_noise");

    idle_start(0, 3, 1'b0, "reject_samples0");
    idle_start(4, 0, 1'b0, "reject_aves0");
    idle_start(4, 2, 1'b1, "start_abort_idle");

    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(1, 12); a = $urandom_range(1, 4);
      tx = $urandom_range(0, 4); dly = $urandom_range(0, 4); gap = $urandom_range(0, 4);
      w = $urandom_range(0, 3); h = $urandom_range(1, 4);
      ab_shot = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, a - 1)) : -1;
      ab_off  = $urandom_range(0, n - 1);
      run(n, a, tx, dly, gap, w, h, ab_shot, ab_off, 1'b1, "random");
    end

    // Asynchronous reset between edges while the transmitter is on
    @(posedge clk); #1;
    cfg_num_samples = SMP_W'(4); cfg_num_aves = AVE_W'(2); cfg_tx_len = TX_W'(6);
    cfg_listen_dly = SMP_W'(1); cfg_gap = GAP_W'(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    check("rst_pre_tx", 32'(tx_pulse), 32'(1));
    reset = 1'b1;
    #1;
    check("rst_async", 32'(obs_v), 32'(0));
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_release", 32'(obs_v), 32'(0));
    last_idx = 0;
    run(2, 1, 1, 0, 0, 0, 1, -1, 0, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
